wb_mem_arbiter: RTL and testbench
=================================

WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning slave no-ack cycles before error; legal range 2-255.
REQ-002 SHALL have clk_i, input, 1: clock.
REQ-003 SHALL have rst_i, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have mN_cyc_i / mN_stb_i / mN_we_i, input, 1 each (N=0 fetch, N=1 data): per-master Wishbone cycle, strobe and write.
REQ-005 SHALL have mN_adr_i, input, 32: per-master byte address.
REQ-006 SHALL have mN_sel_i, input, 4: per-master byte lane select.
REQ-007 SHALL have mN_dat_i, input, 32: per-master write data.
REQ-008 SHALL have mN_dat_o, output, 32: read data to master.
REQ-009 SHALL have mN_ack_o / mN_err_o, output, 1 each: per-master termination.
REQ-010 SHALL have s_cyc_o / s_stb_o / s_we_o, output, 1 each: toward SRAM/ROM wrapper.
REQ-011 SHALL have s_adr_o 32, s_sel_o 4, s_dat_o 32, outputs: forwarded request.
REQ-012 SHALL have s_dat_i 32 and s_ack_i 1, inputs: slave read data and ack.

Function
REQ-013 SHALL implement FSM states IDLE, BUS0, BUS1, with the state held in a register.
REQ-014 In IDLE, the FSM SHALL go to BUSn when only mn_cyc_i is high; on both high it SHALL pick the master not in last_grant (round-robin); with neither high it SHALL stay in IDLE.
REQ-015 In BUSn, the FSM SHALL stay while mn_cyc_i is high; on mn_cyc_i low it SHALL go directly to BUSm if the other master's cyc is high (and set last_grant=n), else go to IDLE.
REQ-016 Arbitration penalty SHALL be exactly one cycle from a request in IDLE to s_stb_o; a direct handover SHALL add no IDLE cycle.
REQ-017 In BUSn, s_cyc/stb/we/adr/sel/dat_o SHALL combinationally equal master n's inputs; in IDLE, s_cyc_o, s_stb_o and s_we_o SHALL be 0.
REQ-018 s_dat_i SHALL drive both mN_dat_o unconditionally; only the granted master SHALL see mn_ack_o = s_ack_i.
REQ-019 s_ack_i arriving in IDLE or for the non-granted master SHALL be dropped.
REQ-020 Single-cycle slave ack SHALL be forwarded unchanged; masters SHALL drop stb after ack (the slave re-acks every other cycle otherwise), and the arbiter SHALL not filter this.
REQ-021 Grant SHALL never change while the granted master's cyc_i is high, including during multi-transfer bursts.

Reset
REQ-022 On rst_i high, the block SHALL force state=IDLE, last_grant=1 (so m0 wins the first tie), and timeout count=0, asynchronously.
REQ-023 During reset, all s_* strobes and mN_ack_o/mN_err_o SHALL be 0; a transfer in flight SHALL be abandoned without termination.

Configuration
REQ-024 With WB_ARB_TIMEOUT_EN defined, a counter SHALL increment each cycle s_cyc_o&s_stb_o&~s_ack_i holds, and clear on ack, on IDLE, or on a grant change.
REQ-025 With WB_ARB_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES-1 with no ack, the granted mn_err_o SHALL pulse 1 cycle next edge, s_stb_o SHALL be forced 0 for that cycle, and the count SHALL clear.
REQ-026 Without WB_ARB_TIMEOUT_EN, mN_err_o SHALL be tied 0, no counter logic SHALL exist, and TIMEOUT_CYCLES SHALL be ignored.

Structure
REQ-027 Package soc_wb_pkg SHALL hold WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4, and the enum arb_state_t {IDLE,BUS0,BUS1}.
REQ-028 The timeout counter SHALL be sub-module wb_timeout_ctr, instantiated only under WB_ARB_TIMEOUT_EN; all else SHALL be flat.

Verification
REQ-029 Bench SHALL cover: m0 read 0x0000_0100 alone, slave ack 1 cycle after stb, s_dat_i=0xDEADBEEF -> s_stb_o 1 cycle after m0_cyc_i, m0_ack_o with m0_dat_o=0xDEADBEEF, m1_ack_o stays 0.
REQ-030 Bench SHALL cover: m0 and m1 request the same cycle after reset -> m0 granted first; m0 drops cyc, m1 granted next cycle with no IDLE.
REQ-031 Bench SHALL cover: three back-to-back contended rounds -> grants alternate m0,m1,m0; m1 write sel=4'b0011, dat=0x1234_5678 appears unchanged on s_sel_o/s_dat_o.
REQ-032 Bench SHALL cover: m1 holds cyc for a 4-beat burst while m0 requests -> m0 waits until m1_cyc_i falls, then is granted.
REQ-033 Bench SHALL cover: with WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave never acks -> m0_err_o pulses at cycle 4 of stb, s_stb_o low 1 cycle; without the macro, m0_err_o stays 0 forever.
REQ-034 Bench SHALL cover: rst_i asserted mid-transfer in BUS1 -> outputs 0 immediately, state IDLE; after release, the next tie grants m0.

Source files
------------

// File: rtl/soc_wb_pkg.sv
// Shared Wishbone widths and the arbiter state encoding for the memory subsystem.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package soc_wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS0 = 2'd1,
        BUS1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Counts consecutive stalled strobe cycles and raises a one-cycle timeout pulse (only built with WB_ARB_TIMEOUT_EN).
// Latency: pulse appears on the edge after the TIMEOUT_CYCLES-th stalled cycle.
// Backpressure: none; it only observes the slave handshake.
`ifdef WB_ARB_TIMEOUT_EN
module wb_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic busy_i,
    input  logic grant_i,
    input  logic stall_i,
    input  logic ack_i,
    output logic tmo_o
);
    logic [7:0] cnt;
    logic       grant_q;
    logic       clr;
    logic [7:0] cnt_base;

    // A new owner, an idle bus or an ack all restart the stall count from zero.
    always_comb begin
        clr      = !busy_i || ack_i || (grant_i != grant_q);
        cnt_base = clr ? 8'd0 : cnt;
    end

    // Stall counter; wraps to zero and fires the pulse when the limit is hit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt     <= 8'd0;
            grant_q <= 1'b0;
            tmo_o   <= 1'b0;
        end else begin
            grant_q <= grant_i;
            tmo_o   <= 1'b0;
            if (stall_i) begin
                if (cnt_base == 8'(TIMEOUT_CYCLES - 1)) begin
                    cnt   <= 8'd0;
                    tmo_o <= 1'b1;
                end else begin
                    cnt <= cnt_base + 8'd1;
                end
            end else begin
                cnt <= cnt_base;
            end
        end
    end

endmodule
`endif

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter (m0 fetch, m1 data) onto one SRAM/ROM slave; optional slave timeout under WB_ARB_TIMEOUT_EN.
// Latency: one cycle from a request in IDLE to s_stb_o; handover between masters adds no idle cycle; data/ack are combinational.
// Backpressure: slave stalls by withholding ack; the losing master waits with cyc high until the owner drops cyc.
module wb_mem_arbiter
    import soc_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [WB_ADR_W-1:0] m0_adr_i,
    input  logic [WB_SEL_W-1:0] m0_sel_i,
    input  logic [WB_DAT_W-1:0] m0_dat_i,
    output logic [WB_DAT_W-1:0] m0_dat_o,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [WB_ADR_W-1:0] m1_adr_i,
    input  logic [WB_SEL_W-1:0] m1_sel_i,
    input  logic [WB_DAT_W-1:0] m1_dat_i,
    output logic [WB_DAT_W-1:0] m1_dat_o,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [WB_ADR_W-1:0] s_adr_o,
    output logic [WB_SEL_W-1:0] s_sel_o,
    output logic [WB_DAT_W-1:0] s_dat_o,
    input  logic [WB_DAT_W-1:0] s_dat_i,
    input  logic                s_ack_i
);
    arb_state_t state;
    logic       last_grant;
    logic       tmo;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_tmo_range
        $error("wb_mem_arbiter: TIMEOUT_CYCLES must be 2..255");
    end

    // Round-robin grant; ownership only moves when the owner releases cyc, and last_grant records who just left.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc_i && m1_cyc_i) state <= last_grant ? BUS0 : BUS1;
                    else if (m0_cyc_i)        state <= BUS0;
                    else if (m1_cyc_i)        state <= BUS1;
                end
                BUS0: begin
                    if (!m0_cyc_i) begin
                        last_grant <= 1'b0;
                        state      <= m1_cyc_i ? BUS1 : IDLE;
                    end
                end
                BUS1: begin
                    if (!m1_cyc_i) begin
                        last_grant <= 1'b1;
                        state      <= m0_cyc_i ? BUS0 : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Steer the owning master onto the slave port; a timeout cycle suppresses the strobe.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_sel_o = '0;
        s_dat_o = '0;
        case (state)
            BUS0: begin
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i && !tmo;
                s_we_o  = m0_we_i;
                s_adr_o = m0_adr_i;
                s_sel_o = m0_sel_i;
                s_dat_o = m0_dat_i;
            end
            BUS1: begin
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i && !tmo;
                s_we_o  = m1_we_i;
                s_adr_o = m1_adr_i;
                s_sel_o = m1_sel_i;
                s_dat_o = m1_dat_i;
            end
            default: ;
        endcase
    end

    // Read data fans out to both masters; only the owner sees the ack, stray acks are dropped.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = (state == BUS0) && s_ack_i;
    assign m1_ack_o = (state == BUS1) && s_ack_i;

`ifdef WB_ARB_TIMEOUT_EN
    logic stall;
    assign stall = s_cyc_o && s_stb_o && !s_ack_i;

    wb_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .busy_i (state != IDLE),
        .grant_i(state == BUS1),
        .stall_i(stall),
        .ack_i  (s_ack_i),
        .tmo_o  (tmo)
    );

    assign m0_err_o = tmo && (state == BUS0);
    assign m1_err_o = tmo && (state == BUS1);
`else
    assign tmo      = 1'b0;
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: directed scenarios plus a randomized run against a round-robin model.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we;
    logic [31:0] m0_adr, m0_wdat, m0_rdat;
    logic [3:0]  m0_sel;
    logic        m0_ack, m0_err;
    logic        m1_cyc, m1_stb, m1_we;
    logic [31:0] m1_adr, m1_wdat, m1_rdat;
    logic [3:0]  m1_sel;
    logic        m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_wdat, s_rdat;
    logic [3:0]  s_sel;
    logic        s_ack;

    int n_checks = 0;
    int n_pass   = 0;

    wb_mem_arbiter #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .m0_cyc_i(m0_cyc),
        .m0_stb_i(m0_stb),
        .m0_we_i (m0_we),
        .m0_adr_i(m0_adr),
        .m0_sel_i(m0_sel),
        .m0_dat_i(m0_wdat),
        .m0_dat_o(m0_rdat),
        .m0_ack_o(m0_ack),
        .m0_err_o(m0_err),
        .m1_cyc_i(m1_cyc),
        .m1_stb_i(m1_stb),
        .m1_we_i (m1_we),
        .m1_adr_i(m1_adr),
        .m1_sel_i(m1_sel),
        .m1_dat_i(m1_wdat),
        .m1_dat_o(m1_rdat),
        .m1_ack_o(m1_ack),
        .m1_err_o(m1_err),
        .s_cyc_o (s_cyc),
        .s_stb_o (s_stb),
        .s_we_o  (s_we),
        .s_adr_o (s_adr),
        .s_sel_o (s_sel),
        .s_dat_o (s_wdat),
        .s_dat_i (s_rdat),
        .s_ack_i (s_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic clear_inputs;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_sel = '0; m0_wdat = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_sel = '0; m1_wdat = '0;
        s_ack = 0; s_rdat = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
        tick();
        sample();
        n_checks++;
        if ({s_cyc, s_stb, s_we} !== 3'b000) $display("FAIL reset_strobes: got %b expected 000", {s_cyc, s_stb, s_we});
        else n_pass++;
        n_checks++;
        if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000)
            $display("FAIL reset_terms: got %b expected 0000", {m0_ack, m0_err, m1_ack, m1_err});
        else n_pass++;
        tick();
        clear_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read;
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h0000_0100; m0_sel = 4'hF;
        sample();
        n_checks++;
        if (s_stb !== 1'b0) $display("FAIL read_penalty_cycle: s_stb got %b expected 0", s_stb);
        else n_pass++;
        tick();
        sample();
        n_checks++;
        if ({s_stb, s_we, s_adr} !== {1'b1, 1'b0, 32'h0000_0100})
            $display("FAIL read_forward: stb/we/adr got %b/%b/%h expected 1/0/00000100", s_stb, s_we, s_adr);
        else n_pass++;
        tick();
        s_ack = 1; s_rdat = 32'hDEADBEEF;
        sample();
        n_checks++;
        if ({m0_ack, m0_rdat} !== {1'b1, 32'hDEADBEEF})
            $display("FAIL read_ack_data: ack/dat got %b/%h expected 1/deadbeef", m0_ack, m0_rdat);
        else n_pass++;
        n_checks++;
        if (m1_ack !== 1'b0) $display("FAIL read_m1_quiet: m1_ack got %b expected 0", m1_ack);
        else n_pass++;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_tie;
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'hA000_0000;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'hB000_0000;
        tick();
        sample();
        n_checks++;
        if ({s_cyc, s_adr} !== {1'b1, 32'hA000_0000})
            $display("FAIL tie_first_m0: cyc/adr got %b/%h expected 1/a0000000", s_cyc, s_adr);
        else n_pass++;
        tick();
        m0_cyc = 0; m0_stb = 0;
        tick();
        sample();
        n_checks++;
        if ({s_cyc, s_adr} !== {1'b1, 32'hB000_0000})
            $display("FAIL tie_handover_m1: cyc/adr got %b/%h expected 1/b0000000", s_cyc, s_adr);
        else n_pass++;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            int exp_g;
            exp_g = r % 2;
            m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h0000_1000 + 32'(r); m0_sel = 4'hF;
            m0_wdat = $urandom;
            m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h0000_2000 + 32'(r); m1_sel = 4'b0011;
            m1_wdat = 32'h1234_5678;
            tick();
            sample();
            n_checks++;
            if (s_adr !== (exp_g == 1 ? m1_adr : m0_adr))
                $display("FAIL b2b_grant round %0d: adr got %h expected master %0d", r, s_adr, exp_g);
            else n_pass++;
            if (exp_g == 1) begin
                n_checks++;
                if ({s_we, s_sel, s_wdat} !== {1'b1, 4'b0011, 32'h1234_5678})
                    $display("FAIL b2b_write_fwd: we/sel/dat got %b/%b/%h expected 1/0011/12345678", s_we, s_sel, s_wdat);
                else n_pass++;
            end
            tick();
            m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_burst;
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h0000_0200; m1_sel = 4'hF;
        tick();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0300;
        for (int b = 0; b < 4; b++) begin
            s_ack = 1; m1_adr = 32'h0000_0200 + 32'(4 * b); m1_wdat = $urandom;
            sample();
            n_checks++;
            if ({s_adr, m1_ack, m0_ack} !== {m1_adr, 1'b1, 1'b0})
                $display("FAIL burst_beat %0d: adr/m1ack/m0ack got %h/%b/%b expected %h/1/0", b, s_adr, m1_ack, m0_ack, m1_adr);
            else n_pass++;
            tick();
        end
        m1_cyc = 0; m1_stb = 0; s_ack = 0;
        tick();
        sample();
        n_checks++;
        if ({s_cyc, s_adr} !== {1'b1, 32'h0000_0300})
            $display("FAIL burst_then_m0: cyc/adr got %b/%h expected 1/00000300", s_cyc, s_adr);
        else n_pass++;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout;
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0400;
`ifdef WB_ARB_TIMEOUT_EN
        sample();
        tick();
        for (int k = 1; k <= 4; k++) begin
            sample();
            n_checks++;
            if ({s_stb, m0_err} !== 2'b10)
                $display("FAIL timeout_wait cycle %0d: stb/err got %b/%b expected 1/0", k, s_stb, m0_err);
            else n_pass++;
            tick();
        end
        sample();
        n_checks++;
        if ({s_stb, m0_err, m1_err} !== 3'b010)
            $display("FAIL timeout_pulse: stb/m0err/m1err got %b/%b/%b expected 0/1/0", s_stb, m0_err, m1_err);
        else n_pass++;
        tick();
        sample();
        n_checks++;
        if ({s_stb, m0_err} !== 2'b10)
            $display("FAIL timeout_after: stb/err got %b/%b expected 1/0", s_stb, m0_err);
        else n_pass++;
`else
        begin
            int errs;
            int stb_low;
            errs = 0;
            stb_low = 0;
            tick();
            for (int k = 0; k < 40; k++) begin
                sample();
                if (m0_err !== 1'b0) errs++;
                if (s_stb !== 1'b1) stb_low++;
                tick();
            end
            n_checks++;
            if (errs !== 0) $display("FAIL no_timeout_err: err cycles got %0d expected 0", errs);
            else n_pass++;
            n_checks++;
            if (stb_low !== 0) $display("FAIL no_timeout_stb: stb low cycles got %0d expected 0", stb_low);
            else n_pass++;
        end
`endif
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h0000_0500;
        tick();
        sample();
        n_checks++;
        if (s_cyc !== 1'b1) $display("FAIL midrst_granted: s_cyc got %b expected 1", s_cyc);
        else n_pass++;
        s_ack = 1;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({s_cyc, s_stb, s_we, m0_ack, m1_ack, m1_err} !== 6'b000000)
            $display("FAIL midrst_outputs: cyc/stb/we/ack0/ack1/err1 got %b expected 000000",
                     {s_cyc, s_stb, s_we, m0_ack, m1_ack, m1_err});
        else n_pass++;
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0600;
        tick();
        rst = 1'b0; s_ack = 0;
        sample();
        n_checks++;
        if (s_cyc !== 1'b0) $display("FAIL midrst_idle: s_cyc got %b expected 0", s_cyc);
        else n_pass++;
        tick();
        sample();
        n_checks++;
        if (s_adr !== 32'h0000_0600) $display("FAIL midrst_tie_m0: adr got %h expected 00000600", s_adr);
        else n_pass++;
        tick();
        clear_inputs();
        tick();
    endtask

    // Randomized traffic against a model of the arbitration rules: owner keeps the bus while its cyc
    // is high; a releasing owner hands to the other master if it waits, else the bus goes idle;
    // from idle a lone requester wins, and on a tie the master that did not hold the bus last wins.
    task automatic test_random;
        int   owner;
        int   last;
        logic cyc [2];
        logic exp_cyc;
        logic [31:0] exp_adr;
        do_reset();
        owner = -1;
        last  = 1;
        for (int i = 0; i < 600; i++) begin
            if (m0_cyc) m0_cyc = ($urandom_range(3) != 0);
            else        m0_cyc = ($urandom_range(2) == 0);
            if (m1_cyc) m1_cyc = ($urandom_range(3) != 0);
            else        m1_cyc = ($urandom_range(2) == 0);
            m0_stb = m0_cyc & 1'($urandom); m0_we = 1'($urandom);
            m1_stb = m1_cyc & 1'($urandom); m1_we = 1'($urandom);
            m0_adr = $urandom; m0_sel = 4'($urandom); m0_wdat = $urandom;
            m1_adr = $urandom; m1_sel = 4'($urandom); m1_wdat = $urandom;
            s_ack = 1'($urandom); s_rdat = $urandom;
            sample();
            exp_cyc = (owner == 0) ? m0_cyc : (owner == 1) ? m1_cyc : 1'b0;
            exp_adr = (owner == 0) ? m0_adr : (owner == 1) ? m1_adr : 32'h0;
            n_checks++;
            if (s_cyc !== exp_cyc) $display("FAIL rand_cyc iter %0d: got %b expected %b", i, s_cyc, exp_cyc);
            else n_pass++;
            n_checks++;
            if (owner >= 0 && s_adr !== exp_adr) $display("FAIL rand_adr iter %0d: got %h expected %h", i, s_adr, exp_adr);
            else n_pass++;
            n_checks++;
            if ({m0_ack, m1_ack} !== {(owner == 0) && s_ack, (owner == 1) && s_ack})
                $display("FAIL rand_ack iter %0d: got %b%b owner %0d s_ack %b", i, m0_ack, m1_ack, owner, s_ack);
            else n_pass++;
            n_checks++;
            if ({m0_rdat, m1_rdat} !== {s_rdat, s_rdat})
                $display("FAIL rand_rdat iter %0d: got %h/%h expected %h", i, m0_rdat, m1_rdat, s_rdat);
            else n_pass++;
            @(posedge clk);
            cyc[0] = m0_cyc;
            cyc[1] = m1_cyc;
            if (owner >= 0 && !cyc[owner]) begin
                last  = owner;
                owner = cyc[1 - owner] ? 1 - owner : -1;
            end else if (owner < 0 && (cyc[0] || cyc[1])) begin
                owner = (cyc[0] && cyc[1]) ? 1 - last : (cyc[0] ? 0 : 1);
            end
            #1;
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_tie();
        test_back_to_back();
        test_burst();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
